// File: rtl/data_mem_ls.sv
// Single-port byte-lane data memory for the load/store stage; response 1+OUT_REG cycles after acceptance.
// One request per cycle when ready; req_ready drops only while the post-reset clear walks the array.
module data_mem_ls #(
  parameter int DEPTH          = 64,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] ptr;
  logic [31:0]   ram [DEPTH];

  logic          accept;
  logic [1:0]    lane;
  logic [AW-1:0] idx;
  logic          f3_ok, misal, range_bad, req_err, wr_en;
  logic [3:0]    be;
  logic [31:0]   wdat;

  logic [31:0]   rd_word;
  logic          s1_vld, s1_err, s1_ld;
  logic [2:0]    s1_f3;
  logic [1:0]    s1_lane;
  logic [7:0]    sel_b;
  logic [15:0]   sel_h;
  logic [31:0]   ld_dat, rdata_s1;

  always_ff @(posedge clk) begin
    if (rst) state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_CLEAR && ptr == AW'(DEPTH-1)) state_nxt = ST_RUN;
  end

  always_comb begin
    busy      = 1'b0;
    req_ready = 1'b0;
    case (state)
      ST_CLEAR: busy      = 1'b1;
      ST_RUN:   req_ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                    ptr <= '0;
    else if (state == ST_CLEAR) ptr <= ptr + 1'b1;
  end

  assign accept = req_valid & req_ready & ~rst;
  assign lane   = req_addr[1:0];
  assign idx    = req_addr[AW+1:2];

  always_comb begin
    f3_ok = req_we ? (req_funct3 <= 3'd2)
                   : (req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    case (req_funct3[1:0])
      2'd1:    misal = lane[0];
      2'd2:    misal = (lane != 2'd0);
      default: misal = 1'b0;
    endcase
    range_bad = |req_addr[31:AW+2];
    req_err   = ~f3_ok | misal | range_bad;
  end

  assign wr_en = accept & req_we & ~req_err;

  // Data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    case (req_funct3[1:0])
      2'd0: begin
        be   = 4'b0001 << lane;
        wdat = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        be   = 4'b0011 << lane;
        wdat = {2{req_wdata[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        wdat = req_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_CLEAR) begin
        ram[ptr] <= '0;
      end else if (wr_en) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) ram[idx][8*b +: 8] <= wdat[8*b +: 8];
      end
    end
    if (accept) rd_word <= ram[idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_err  <= 1'b0;
      s1_ld   <= 1'b0;
      s1_f3   <= '0;
      s1_lane <= '0;
    end else begin
      s1_vld  <= accept;
      s1_err  <= accept & req_err;
      s1_ld   <= accept & ~req_we & ~req_err;
      s1_f3   <= req_funct3;
      s1_lane <= lane;
    end
  end

  always_comb begin
    sel_b = rd_word[8*s1_lane +: 8];
    sel_h = s1_lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (s1_f3)
      3'd0:    ld_dat = {{24{sel_b[7]}}, sel_b};
      3'd1:    ld_dat = {{16{sel_h[15]}}, sel_h};
      3'd2:    ld_dat = rd_word;
      3'd4:    ld_dat = {24'd0, sel_b};
      3'd5:    ld_dat = {16'd0, sel_h};
      default: ld_dat = '0;
    endcase
    rdata_s1 = s1_ld ? ld_dat : '0;
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      always_ff @(posedge clk) begin
        if (rst) begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end else begin
          resp_valid <= s1_vld;
          resp_err   <= s1_err;
          resp_rdata <= rdata_s1;
        end
      end
    end else begin : g_direct
      assign resp_valid = s1_vld;
      assign resp_err   = s1_err;
      assign resp_rdata = rdata_s1;
    end
  endgenerate

endmodule
